data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 173 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with fixed response latency.
// Detects misaligned, out-of-range and illegal-size requests. Stores apply byte-lane masks.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_v,
    output logic        req_rdy,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        rsp_v,
    input  logic        rsp_rdy,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        we_q, signed_q;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept, enter_resp, mem_we;
    logic        cur_we, cur_signed, cur_err;
    logic [31:0] cur_addr, cur_wdata;
    logic [1:0]  cur_size, lane;
    logic        misaligned, out_of_range;
    logic [AW-1:0] idx;
    logic [3:0]  be;
    logic [31:0] wshift, rshift, load_val;

    assign accept = req_v && (state_q == StIdle);

    // With LATENCY=1 the transaction enters RESP on its accepting edge, so the live inputs apply.
    always_comb begin
        if (state_q == StIdle) begin
            cur_we     = req_we;
            cur_signed = req_signed;
            cur_addr   = req_addr;
            cur_wdata  = req_wdata;
            cur_size   = req_size;
        end else begin
            cur_we     = we_q;
            cur_signed = signed_q;
            cur_addr   = addr_q;
            cur_wdata  = wdata_q;
            cur_size   = size_q;
        end
    end

    assign enter_resp = (accept && (LATENCY == 1)) || ((state_q == StWait) && (cnt_q == 4'd0));

    assign lane         = cur_addr[1:0];
    assign idx          = cur_addr[AW+1:2];
    assign misaligned   = ((cur_size == 2'd1) && cur_addr[0]) ||
                          ((cur_size == 2'd2) && (cur_addr[1:0] != 2'b00));
    assign out_of_range = {2'b00, cur_addr[31:2]} >= DEPTH_WORDS;
    assign cur_err      = (cur_size == 2'd3) || misaligned || out_of_range;
    assign mem_we       = rst_n && enter_resp && cur_we && !cur_err;

    always_comb begin
        be = 4'b0000;
        case (cur_size)
            2'd0:    be = 4'b0001 << lane;
            2'd1:    be = 4'b0011 << lane;
            2'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign wshift = cur_wdata << {lane, 3'b000};
    assign rshift = mem[idx] >> {lane, 3'b000};

    always_comb begin
        load_val = rshift;
        case (cur_size)
            2'd0:    load_val = {{24{cur_signed & rshift[7]}}, rshift[7:0]};
            2'd1:    load_val = {{16{cur_signed & rshift[15]}}, rshift[15:0]};
            default: load_val = rshift;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_v) begin
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? StResp : StWait;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_rdy) begin
                    state_d = StIdle;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (enter_resp) begin
            err_d   = cur_err;
            rdata_d = (cur_err || cur_we) ? 32'h0 : load_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            size_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q     <= req_we;
                signed_q <= req_signed;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                size_q   <= req_size;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wshift[8*i +: 8];
                end
            end
        end
    end

    assign req_rdy   = (state_q == StIdle);
    assign rsp_v     = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed scenarios followed by random traffic
// checked against a byte-addressed reference memory.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_v = 1'b0;
    logic        req_rdy;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic        rsp_v;
    logic        rsp_rdy = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [32:0] sb_q[$];
    logic [7:0]  rmem [int unsigned];
    bit          rand_rdy = 1'b0;
    bit          force_rdy = 1'b1;

    data_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_v     (req_v),
        .req_rdy   (req_rdy),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .req_signed(req_signed),
        .rsp_v     (rsp_v),
        .rsp_rdy   (rsp_rdy),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: memory as individual bytes, result built with plain arithmetic.
    function automatic logic [32:0] model(input logic we, input logic [31:0] addr,
                                          input logic [31:0] wdata, input logic [1:0] size,
                                          input logic sgn);
        int unsigned nb;
        logic [31:0] v;
        bit err;
        nb  = 1 << size;
        err = (size == 2'd3) || ((addr % nb) != 0) || ((addr / 4) >= DEPTH);
        if (err) return {1'b1, 32'h0};
        if (we) begin
            for (int i = 0; i < int'(nb); i++) rmem[addr + i] = wdata[8*i +: 8];
            return {1'b0, 32'h0};
        end
        v = 32'h0;
        for (int i = 0; i < int'(nb); i++) v = v | (32'(rmem[addr + i]) << (8 * i));
        if (sgn && nb < 4 && v[8*nb-1]) v = v - (32'd1 << (8 * nb));
        return {1'b0, v};
    endfunction

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic sgn, input bit use_exp,
                         input logic [31:0] exp_data, input bit exp_err, input bit keep_v);
        logic [32:0] m;
        int k;
        k = 0;
        @(negedge clk);
        while (!req_rdy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("req_rdy_before_issue", req_rdy, 1);
        req_v      = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_size   = size;
        req_signed = sgn;
        @(posedge clk);
        m = model(we, addr, wdata, size, sgn);
        if (use_exp) sb_q.push_back({exp_err, exp_data});
        else sb_q.push_back(m);
        #1;
        check("req_rdy_after_accept", req_rdy, 0);
        if (!keep_v) begin
            // Junk on the request bus while busy must be ignored.
            req_v      = 1'b0;
            req_we     = 1'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
            req_size   = 2'($urandom);
        end
    endtask

    task automatic wait_valid(input bit chk_lat);
        int k;
        k = 0;
        while (!rsp_v && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (chk_lat) check("rsp_latency", k, LAT);
    endtask

    task automatic wait_rsp(input bit chk_lat);
        int k;
        wait_valid(chk_lat);
        k = 0;
        while (sb_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("rsp_consumed", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rsp_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : force_rdy;
        end
    end

    // Monitor: compares every consumed response and checks hold stability under backpressure.
    initial begin
        logic [32:0] e;
        logic [31:0] h_data;
        logic        h_err;
        bit          held;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || !rsp_v) begin
                held = 1'b0;
            end else begin
                check("req_rdy_low_in_resp", req_rdy, 0);
                if (held) begin
                    check("hold_rdata", rsp_rdata, h_data);
                    check("hold_err", rsp_err, h_err);
                end
                if (rsp_rdy) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b, required none",
                                 rsp_rdata, rsp_err);
                    end else begin
                        e = sb_q.pop_front();
                        check("rsp_rdata", rsp_rdata, e[31:0]);
                        check("rsp_err", rsp_err, e[32]);
                    end
                    held = 1'b0;
                end else begin
                    held   = 1'b1;
                    h_data = rsp_rdata;
                    h_err  = rsp_err;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int sel;

        #12;
        check("reset_req_rdy", req_rdy, 1);
        check("reset_rsp_v", rsp_v, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word store/load round trip
        issue(1, 32'h10, 32'hDEADBEEF, 2, 0, 1, 32'h0, 0, 0);
        wait_rsp(1);
        issue(0, 32'h10, 32'h0, 2, 0, 1, 32'hDEADBEEF, 0, 0);
        wait_rsp(1);

        // Byte extension and half-word store
        issue(0, 32'h13, 32'h0, 0, 1, 1, 32'hFFFFFFDE, 0, 0);
        wait_rsp(1);
        issue(0, 32'h13, 32'h0, 0, 0, 1, 32'h000000DE, 0, 0);
        wait_rsp(1);
        issue(1, 32'h12, 32'h1234, 1, 0, 1, 32'h0, 0, 0);
        wait_rsp(1);
        issue(0, 32'h10, 32'h0, 2, 0, 1, 32'h1234BEEF, 0, 0);
        wait_rsp(1);

        // Errors leave memory untouched
        issue(0, 32'h11, 32'h0, 1, 0, 1, 32'h0, 1, 0);
        wait_rsp(1);
        issue(0, 32'h12, 32'h0, 2, 0, 1, 32'h0, 1, 0);
        wait_rsp(1);
        issue(0, 32'h10, 32'h0, 3, 0, 1, 32'h0, 1, 0);
        wait_rsp(1);
        issue(1, 32'h12, 32'hCAFEF00D, 2, 0, 1, 32'h0, 1, 0);
        wait_rsp(1);
        issue(1, 32'h10, 32'hCAFEF00D, 3, 0, 1, 32'h0, 1, 0);
        wait_rsp(1);
        issue(0, 32'h10, 32'h0, 2, 0, 1, 32'h1234BEEF, 0, 0);
        wait_rsp(1);
        issue(0, 4 * DEPTH, 32'h0, 2, 0, 1, 32'h0, 1, 0);
        wait_rsp(1);
        issue(1, 4 * DEPTH, 32'h11223344, 2, 0, 1, 32'h0, 1, 0);
        wait_rsp(1);

        // Backpressure with a request held on the bus
        force_rdy = 1'b0;
        issue(0, 32'h10, 32'h0, 2, 0, 1, 32'h1234BEEF, 0, 1);
        req_we   = 1'b0;
        req_addr = 32'h10;
        req_size = 2'd2;
        wait_valid(1);
        repeat (5) begin
            @(posedge clk);
            #2;
            check("bp_rsp_v", rsp_v, 1);
            check("bp_req_rdy", req_rdy, 0);
        end
        force_rdy = 1'b1;
        rsp_rdy   = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle_after_consume", req_rdy, 1);
        check("bp_rsp_v_dropped", rsp_v, 0);
        @(posedge clk);
        sb_q.push_back({1'b0, 32'h1234BEEF});
        #1;
        check("bp_next_accepted", req_rdy, 0);
        req_v = 1'b0;
        wait_rsp(1);

        // Reset during WAIT aborts a store
        issue(1, 32'h20, 32'h55667788, 2, 0, 1, 32'h0, 0, 0);
        wait_rsp(1);
        @(negedge clk);
        req_v     = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hAAAAAAAA;
        req_size  = 2'd2;
        @(posedge clk);
        #1;
        req_v = 1'b0;
        check("abort_busy", req_rdy, 0);
        rst_n = 1'b0;
        #2;
        check("abort_reset_req_rdy", req_rdy, 1);
        check("abort_reset_rsp_v", rsp_v, 0);
        check("abort_reset_rsp_err", rsp_err, 0);
        check("abort_reset_rsp_rdata", rsp_rdata, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #2;
            check("abort_no_rsp", rsp_v, 0);
        end
        issue(0, 32'h20, 32'h0, 2, 0, 1, 32'h55667788, 0, 0);
        wait_rsp(1);

        // Random traffic over a fully initialised 64-byte window
        for (int w = 0; w < 16; w++) begin
            issue(1, 32'(4 * w), $urandom, 2, 0, 0, 32'h0, 0, 0);
            wait_rsp(1);
        end
        rand_rdy = 1'b1;
        for (int n = 0; n < 150; n++) begin
            sel = int'($urandom_range(0, 7));
            if (sel == 0) a = 32'(4 * DEPTH) + $urandom_range(0, 63);
            else if (sel == 1) a = {1'b1, 31'($urandom)};
            else a = 32'($urandom_range(0, 63));
            issue(1'($urandom), a, $urandom, 2'($urandom), 1'($urandom), 0, 32'h0, 0, 0);
            wait_rsp(1);
        end
        rand_rdy = 1'b0;

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
